ahb_master_retime_param: RTL and testbench
==========================================

AHB_MASTER_RETIME_PARAM -- requirements
Module: ahb_master_retime_param

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, address width.
REQ-002 SHALL have parameter: DATA_W, 32, data width; legal values are 32, 64 and 128.
REQ-003 SHALL have parameter: BURST_PASS, 0, burst mode; 0 = split bursts into SINGLE transfers, 1 = forward bursts with BUSY fill.
REQ-004 SHALL have ports:
- hclk  in  1  clock; one clock, all logic rises on posedge.
- resetn  in  1  reset; asynchronous, active-low.
- ahb_mmst_haddr/htrans/hwrite/hsize/hburst/hprot/hlock  in  ADDR_W/2/1/3/3/4/1  upstream address-phase controls.
- ahb_mmst_hwdata  in  DATA_W  upstream write data.
- ahb_mmst_hrdata  out  DATA_W  upstream read data.
- ahb_mmst_hready  out  1  upstream ready.
- ahb_mmst_hresp  out  2  upstream response.
- ahb_mst_haddr/htrans/hwrite/hsize/hburst/hprot/hlock  out  same widths  downstream controls.
- ahb_mst_hwdata  out  DATA_W  downstream write data.
- ahb_mst_hrdata  in  DATA_W  downstream read data.
- ahb_mst_hready  in  1  downstream ready.
- ahb_mst_hresp  in  2  downstream response.
REQ-005 All ahb_mst_* outputs and ahb_mmst_hrdata/hresp SHALL be driven directly from flops; ahb_mmst_hready SHALL be decoded from state only.

Function
REQ-006 States: IDLE, ADDR, DATA, ERR1.
REQ-007 IDLE behaviour:
- Drives hready=1.
- Upstream NONSEQ or SEQ: capture all controls into ahb_mst_*, go to ADDR.
- Upstream IDLE or BUSY: ignored.
REQ-008 ADDR behaviour:
- ahb_mst_htrans is valid; hready=0.
- First ADDR cycle: capture ahb_mmst_hwdata into ahb_mst_hwdata; hold until next capture.
- ahb_mst_hready=1: go to DATA, and ahb_mst_htrans becomes IDLE (BUSY per REQ-013).
REQ-009 DATA behaviour:
- hready=0.
- On ahb_mst_hready=1: register hrdata (reads only) and hresp.
- hresp OKAY: go to IDLE.
- Any non-OKAY: go to ERR1.
REQ-010 ERR1 behaviour:
- Drives hready=0 and the registered non-OKAY hresp.
- Next cycle: go to IDLE with the same hresp held for exactly one cycle (two-cycle response), then hresp returns to OKAY.
REQ-011 Latency: upstream address accept to upstream data completion = 2 + (downstream ADDR waits) + (downstream DATA waits) cycles; minimum is hready low for 2 cycles.
REQ-012 BURST_PASS=0:
- Downstream htrans is always NONSEQ.
- Downstream hburst is always SINGLE (000).
- Upstream SEQ is reissued as NONSEQ.
REQ-013 BURST_PASS=1:
- Captured htrans and hburst are forwarded unchanged.
- burst_active sets on capture with hburst≠SINGLE.
- While burst_active, non-ADDR cycles drive BUSY instead of IDLE.
- burst_active clears when IDLE sees upstream IDLE or NONSEQ (a NONSEQ starts a new burst), and on entry to ERR1; downstream htrans is then IDLE.
REQ-014 In IDLE, an upstream transfer is captured in the same cycle that hready=1 completes the previous data phase (back-to-back); no bubble is inserted.
REQ-015 Upstream hrdata SHALL hold its last value outside read completion; writes do not update it.

Reset
REQ-016 On resetn low, immediately and regardless of state:
- state = IDLE.
- ahb_mst_htrans = IDLE; ahb_mmst_hready = 1; ahb_mmst_hresp = OKAY.
- All other registered outputs = 0; burst_active = 0.
REQ-017 Reset mid-transfer abandons the transfer; no partial response is issued after release.

Structure
REQ-018 htrans, hburst and hresp encodings and the state encoding SHALL live in shared package ahb_pkg.
REQ-019 Single module; no sub-module.

Verification
REQ-020 Single write: upstream NONSEQ haddr=0x1000, hwdata=0xA5A5A5A5, downstream hready=1 -> downstream NONSEQ one cycle later, hwdata=0xA5A5A5A5 in DATA, upstream hready low for exactly 2 cycles.
REQ-021 Read with 3 downstream wait states in DATA, hrdata=0x12345678 -> upstream hready low for 5 cycles, upstream hrdata=0x12345678 with hresp OKAY.
REQ-022 Downstream ERROR on a read at 0x2000 -> upstream sees (hready=0, hresp=01) then (hready=1, hresp=01); BURST_PASS=1 burst terminates with downstream IDLE.
REQ-023 BURST_PASS=0 INCR4 at 0x3000 -> 4 downstream NONSEQ SINGLE transfers at 0x3000/4/8/C with IDLE between them.
REQ-024 BURST_PASS=1 INCR4 at 0x3000 -> downstream sequence NONSEQ, BUSY, SEQ, BUSY…; final beat followed by IDLE once upstream presents IDLE.
REQ-025 Assert resetn=0 during DATA of a read with a pending downstream wait -> outputs take reset values asynchronously; after release, upstream hready=1 and no response is issued.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the retime-master state encoding.
// Contents:
//   htrans_e - transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hburst_e - burst type (SINGLE/INCR/WRAPx/INCRx)
//   hresp_e  - slave response (OKAY/ERROR/RETRY/SPLIT)
//   state_e  - retime master FSM states
package ahb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BurstSingle = 3'b000,
    BurstIncr   = 3'b001,
    BurstWrap4  = 3'b010,
    BurstIncr4  = 3'b011,
    BurstWrap8  = 3'b100,
    BurstIncr8  = 3'b101,
    BurstWrap16 = 3'b110,
    BurstIncr16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    RespOkay  = 2'b00,
    RespError = 2'b01,
    RespRetry = 2'b10,
    RespSplit = 2'b11
  } hresp_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAddr = 2'b01,
    StData = 2'b10,
    StErr1 = 2'b11
  } state_e;

endpackage

// File: rtl/ahb_master_retime_param.sv
// AHB master-side retiming stage. Accepts one upstream transfer at a time, reissues it on the
// downstream master port from flops, and returns read data / response upstream from flops.
// Upstream hready is decoded from the FSM state only, so nothing combinational crosses the stage.
//
// Parameters:
//   ADDR_W     - address width
//   DATA_W     - data width (32, 64 or 128)
//   BURST_PASS - 0: every transfer goes out as NONSEQ SINGLE
//                1: htrans/hburst forwarded, BUSY fills the gaps inside a burst
// Ports:
//   hclk, resetn          - clock, asynchronous active-low reset
//   ahb_mmst_*  (inputs)  - upstream address phase controls and write data
//   ahb_mmst_hrdata/hready/hresp (outputs) - upstream data phase return
//   ahb_mst_*   (outputs) - downstream address phase controls and write data
//   ahb_mst_hrdata/hready/hresp (inputs)   - downstream data phase return
module ahb_master_retime_param
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BURST_PASS = 0
) (
  input  logic              hclk,
  input  logic              resetn,
  // Upstream
  input  logic [ADDR_W-1:0] ahb_mmst_haddr,
  input  logic [1:0]        ahb_mmst_htrans,
  input  logic              ahb_mmst_hwrite,
  input  logic [2:0]        ahb_mmst_hsize,
  input  logic [2:0]        ahb_mmst_hburst,
  input  logic [3:0]        ahb_mmst_hprot,
  input  logic              ahb_mmst_hlock,
  input  logic [DATA_W-1:0] ahb_mmst_hwdata,
  output logic [DATA_W-1:0] ahb_mmst_hrdata,
  output logic              ahb_mmst_hready,
  output logic [1:0]        ahb_mmst_hresp,
  // Downstream
  output logic [ADDR_W-1:0] ahb_mst_haddr,
  output logic [1:0]        ahb_mst_htrans,
  output logic              ahb_mst_hwrite,
  output logic [2:0]        ahb_mst_hsize,
  output logic [2:0]        ahb_mst_hburst,
  output logic [3:0]        ahb_mst_hprot,
  output logic              ahb_mst_hlock,
  output logic [DATA_W-1:0] ahb_mst_hwdata,
  input  logic [DATA_W-1:0] ahb_mst_hrdata,
  input  logic              ahb_mst_hready,
  input  logic [1:0]        ahb_mst_hresp
);

  state_e     state_q;
  logic       burst_active_q;
  // Set for the first ADDR cycle: that is the upstream data phase carrying hwdata.
  logic       wdata_pend_q;
  logic       up_valid;
  logic [1:0] idle_fill;

  assign up_valid  = (ahb_mmst_htrans == TransNonseq) || (ahb_mmst_htrans == TransSeq);
  // Outside the address phase the downstream bus idles, or marks BUSY while a burst is open.
  assign idle_fill = burst_active_q ? TransBusy : TransIdle;

  assign ahb_mmst_hready = (state_q == StIdle);

  always_ff @(posedge hclk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= StIdle;
      burst_active_q  <= 1'b0;
      wdata_pend_q    <= 1'b0;
      ahb_mmst_hrdata <= '0;
      ahb_mmst_hresp  <= RespOkay;
      ahb_mst_haddr   <= '0;
      ahb_mst_htrans  <= TransIdle;
      ahb_mst_hwrite  <= 1'b0;
      ahb_mst_hsize   <= '0;
      ahb_mst_hburst  <= BurstSingle;
      ahb_mst_hprot   <= '0;
      ahb_mst_hlock   <= 1'b0;
      ahb_mst_hwdata  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Any held error response lasts only this one ready cycle.
          ahb_mmst_hresp <= RespOkay;
          if (up_valid) begin
            ahb_mst_haddr <= ahb_mmst_haddr;
            ahb_mst_hwrite <= ahb_mmst_hwrite;
            ahb_mst_hsize <= ahb_mmst_hsize;
            ahb_mst_hprot <= ahb_mmst_hprot;
            ahb_mst_hlock <= ahb_mmst_hlock;
            if (BURST_PASS != 0) begin
              ahb_mst_htrans <= ahb_mmst_htrans;
              ahb_mst_hburst <= ahb_mmst_hburst;
              burst_active_q <= (ahb_mmst_hburst != BurstSingle);
            end else begin
              // Bursts are split: each beat, SEQ included, leaves as its own NONSEQ SINGLE.
              ahb_mst_htrans <= TransNonseq;
              ahb_mst_hburst <= BurstSingle;
              burst_active_q <= 1'b0;
            end
            wdata_pend_q <= 1'b1;
            state_q      <= StAddr;
          end else if (ahb_mmst_htrans == TransIdle) begin
            burst_active_q <= 1'b0;
            ahb_mst_htrans <= TransIdle;
          end
          // Upstream BUSY: keep whatever fill is on the bus.
        end

        StAddr: begin
          if (wdata_pend_q) begin
            ahb_mst_hwdata <= ahb_mmst_hwdata;
            wdata_pend_q   <= 1'b0;
          end
          if (ahb_mst_hready) begin
            ahb_mst_htrans <= idle_fill;
            state_q        <= StData;
          end
        end

        StData: begin
          if (ahb_mst_hready) begin
            if (!ahb_mst_hwrite) begin
              ahb_mmst_hrdata <= ahb_mst_hrdata;
            end
            ahb_mmst_hresp <= ahb_mst_hresp;
            if (ahb_mst_hresp == RespOkay) begin
              state_q <= StIdle;
            end else begin
              // An error ends any open burst; the downstream bus goes fully idle.
              burst_active_q <= 1'b0;
              ahb_mst_htrans <= TransIdle;
              state_q        <= StErr1;
            end
          end
        end

        StErr1: begin
          // First cycle of the two-cycle response; hresp is held into the next IDLE cycle.
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master_retime_param.sv
// Bench for ahb_master_retime_param. Two instances (BURST_PASS=0 and 1) share all inputs; their
// timing is identical, only the forwarded htrans/hburst differ. Directed table vectors, an INCR4
// burst, randomized transfers against a transaction-level model, and a mid-transfer reset.
module tb_ahb_master_retime_param;
  import ahb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    int          aw;
    int          dw;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          exp_lo;
    logic [31:0] exp_hrdata;
    logic [1:0]  exp_hresp;
  } vec_t;

  logic hclk = 1'b0;
  logic resetn;
  always #5 hclk = ~hclk;

  logic [AW-1:0] up_haddr;
  logic [1:0]    up_htrans;
  logic          up_hwrite;
  logic [2:0]    up_hsize;
  logic [2:0]    up_hburst;
  logic [3:0]    up_hprot;
  logic          up_hlock;
  logic [DW-1:0] up_hwdata;
  logic [DW-1:0] dn_hrdata;
  logic          dn_hready;
  logic [1:0]    dn_hresp;

  logic [1:0][DW-1:0] o_hrdata;
  logic [1:0]         o_hready;
  logic [1:0][1:0]    o_hresp;
  logic [1:0][AW-1:0] o_haddr;
  logic [1:0][1:0]    o_htrans;
  logic [1:0]         o_hwrite;
  logic [1:0][2:0]    o_hsize;
  logic [1:0][2:0]    o_hburst;
  logic [1:0][3:0]    o_hprot;
  logic [1:0]         o_hlock;
  logic [1:0][DW-1:0] o_hwdata;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    ahb_master_retime_param #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .BURST_PASS(k)
    ) u_dut (
      .hclk           (hclk),
      .resetn         (resetn),
      .ahb_mmst_haddr (up_haddr),
      .ahb_mmst_htrans(up_htrans),
      .ahb_mmst_hwrite(up_hwrite),
      .ahb_mmst_hsize (up_hsize),
      .ahb_mmst_hburst(up_hburst),
      .ahb_mmst_hprot (up_hprot),
      .ahb_mmst_hlock (up_hlock),
      .ahb_mmst_hwdata(up_hwdata),
      .ahb_mmst_hrdata(o_hrdata[k]),
      .ahb_mmst_hready(o_hready[k]),
      .ahb_mmst_hresp (o_hresp[k]),
      .ahb_mst_haddr  (o_haddr[k]),
      .ahb_mst_htrans (o_htrans[k]),
      .ahb_mst_hwrite (o_hwrite[k]),
      .ahb_mst_hsize  (o_hsize[k]),
      .ahb_mst_hburst (o_hburst[k]),
      .ahb_mst_hprot  (o_hprot[k]),
      .ahb_mst_hlock  (o_hlock[k]),
      .ahb_mst_hwdata (o_hwdata[k]),
      .ahb_mst_hrdata (dn_hrdata),
      .ahb_mst_hready (dn_hready),
      .ahb_mst_hresp  (dn_hresp)
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Completion expected in the next upstream-ready cycle.
  logic        pend = 1'b0;
  logic [31:0] pend_rdata;
  logic [1:0]  pend_resp;
  logic [1:0]  pend_fill1;

  // Model: upstream hrdata is the most recent read's data.
  logic [31:0] mdl_rdata = 32'h0;

  vec_t tab [6];
  vec_t cur;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    r.exp_lo = 2 + v.aw + v.dw + ((v.resp != RespOkay) ? 1 : 0);
    if (!v.write) mdl_rdata = v.rdata;
    r.exp_hrdata = mdl_rdata;
    r.exp_hresp  = v.resp;
    return r;
  endfunction

  // Called at the negedge of a cycle where the DUT must be ready.
  task automatic idle_check(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s ready dut%0d", tag, k), 64'(o_hready[k]), 64'd1);
      if (pend) begin
        chk($sformatf("%s hrdata dut%0d", tag, k), 64'(o_hrdata[k]), 64'(pend_rdata));
        chk($sformatf("%s hresp dut%0d", tag, k), 64'(o_hresp[k]), 64'(pend_resp));
      end
    end
    if (pend) begin
      chk($sformatf("%s idle htrans dut0", tag), 64'(o_htrans[0]), 64'(TransIdle));
      chk($sformatf("%s idle htrans dut1", tag), 64'(o_htrans[1]), 64'(pend_fill1));
    end
    pend = 1'b0;
  endtask

  // Enter at #1 after a posedge with the DUT expected in IDLE; leaves at #1 after the
  // posedge that completes the transfer (completion checked by the next ready cycle).
  task automatic run_xfer(input vec_t v, input string tag);
    int         lo;
    logic [1:0] fill1;
    lo    = 0;
    fill1 = (v.hburst != BurstSingle) ? TransBusy : TransIdle;
    up_htrans = v.htrans;
    up_haddr  = v.addr;
    up_hwrite = v.write;
    up_hburst = v.hburst;
    up_hsize  = 3'd2;
    up_hprot  = 4'h3;
    up_hlock  = v.addr[4];
    dn_hready = 1'b1;
    dn_hresp  = RespOkay;
    @(negedge hclk);
    idle_check(tag);
    @(posedge hclk); #1;
    up_htrans = TransIdle;
    up_hwdata = v.wdata;
    for (int i = 0; i <= v.aw; i++) begin
      dn_hready = (i == v.aw);
      @(negedge hclk);
      if (!o_hready[0]) lo++;
      chk($sformatf("%s addr htrans dut0", tag), 64'(o_htrans[0]), 64'(TransNonseq));
      chk($sformatf("%s addr htrans dut1", tag), 64'(o_htrans[1]), 64'(v.htrans));
      if (i == 0) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("%s haddr dut%0d", tag, k), 64'(o_haddr[k]), 64'(v.addr));
          chk($sformatf("%s hwrite dut%0d", tag, k), 64'(o_hwrite[k]), 64'(v.write));
          chk($sformatf("%s hctl dut%0d", tag, k), 64'({o_hsize[k], o_hprot[k], o_hlock[k]}),
              64'({3'd2, 4'h3, v.addr[4]}));
          chk($sformatf("%s addr hresp dut%0d", tag, k), 64'(o_hresp[k]), 64'(RespOkay));
        end
        chk($sformatf("%s hburst dut0", tag), 64'(o_hburst[0]), 64'(BurstSingle));
        chk($sformatf("%s hburst dut1", tag), 64'(o_hburst[1]), 64'(v.hburst));
      end
      @(posedge hclk); #1;
      up_hwdata = ~v.wdata;  // only the first ADDR cycle's data may be taken
    end
    for (int i = 0; i <= v.dw; i++) begin
      dn_hready = (i == v.dw);
      dn_hrdata = (i == v.dw) ? v.rdata : $urandom();
      dn_hresp  = (i == v.dw) ? v.resp : RespOkay;
      @(negedge hclk);
      if (!o_hready[0]) lo++;
      chk($sformatf("%s data htrans dut0", tag), 64'(o_htrans[0]), 64'(TransIdle));
      chk($sformatf("%s data htrans dut1", tag), 64'(o_htrans[1]), 64'(fill1));
      if (v.write) begin
        chk($sformatf("%s hwdata dut0", tag), 64'(o_hwdata[0]), 64'(v.wdata));
        chk($sformatf("%s hwdata dut1", tag), 64'(o_hwdata[1]), 64'(v.wdata));
      end
      @(posedge hclk); #1;
    end
    dn_hready = 1'b1;
    dn_hresp  = RespOkay;
    dn_hrdata = $urandom();
    if (v.resp != RespOkay) begin
      @(negedge hclk);
      if (!o_hready[0]) lo++;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("%s err1 hresp dut%0d", tag, k), 64'(o_hresp[k]), 64'(v.resp));
        chk($sformatf("%s err1 htrans dut%0d", tag, k), 64'(o_htrans[k]), 64'(TransIdle));
      end
      @(posedge hclk); #1;
      fill1 = TransIdle;
    end
    chk($sformatf("%s hready low cycles", tag), 64'(lo), 64'(v.exp_lo));
    pend       = 1'b1;
    pend_rdata = v.exp_hrdata;
    pend_resp  = v.exp_hresp;
    pend_fill1 = fill1;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    up_htrans = TransIdle;
    dn_hready = 1'b1;
    dn_hresp  = RespOkay;
    for (int i = 0; i < n; i++) begin
      @(negedge hclk);
      if (i == 0) begin
        idle_check(tag);
      end else begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("%s gap ready dut%0d", tag, k), 64'(o_hready[k]), 64'd1);
          chk($sformatf("%s gap hresp dut%0d", tag, k), 64'(o_hresp[k]), 64'(RespOkay));
          chk($sformatf("%s gap htrans dut%0d", tag, k), 64'(o_htrans[k]), 64'(TransIdle));
        end
      end
      @(posedge hclk); #1;
    end
  endtask

  task automatic reset_values(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s hready dut%0d", tag, k), 64'(o_hready[k]), 64'd1);
      chk($sformatf("%s hresp dut%0d", tag, k), 64'(o_hresp[k]), 64'(RespOkay));
      chk($sformatf("%s htrans dut%0d", tag, k), 64'(o_htrans[k]), 64'(TransIdle));
      chk($sformatf("%s haddr dut%0d", tag, k), 64'(o_haddr[k]), 64'd0);
      chk($sformatf("%s hrdata dut%0d", tag, k), 64'(o_hrdata[k]), 64'd0);
      chk($sformatf("%s hwdata dut%0d", tag, k), 64'(o_hwdata[k]), 64'd0);
      chk($sformatf("%s ctl dut%0d", tag, k),
          64'({o_hwrite[k], o_hsize[k], o_hburst[k], o_hprot[k], o_hlock[k]}), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gap;
    tab[0] = '{write: 1'b1, addr: 32'h1000, wdata: 32'hA5A5A5A5, htrans: TransNonseq,
               hburst: BurstSingle, aw: 0, dw: 0, rdata: 32'h0, resp: RespOkay,
               exp_lo: 2, exp_hrdata: 32'h0, exp_hresp: RespOkay};
    tab[1] = '{write: 1'b0, addr: 32'h1004, wdata: 32'h0, htrans: TransNonseq,
               hburst: BurstSingle, aw: 0, dw: 3, rdata: 32'h12345678, resp: RespOkay,
               exp_lo: 5, exp_hrdata: 32'h12345678, exp_hresp: RespOkay};
    tab[2] = '{write: 1'b1, addr: 32'h1008, wdata: 32'h0F0F0F0F, htrans: TransNonseq,
               hburst: BurstSingle, aw: 2, dw: 1, rdata: 32'h0, resp: RespOkay,
               exp_lo: 5, exp_hrdata: 32'h12345678, exp_hresp: RespOkay};
    tab[3] = '{write: 1'b0, addr: 32'h2000, wdata: 32'h0, htrans: TransNonseq,
               hburst: BurstIncr4, aw: 0, dw: 0, rdata: 32'hDEADBEEF, resp: RespError,
               exp_lo: 3, exp_hrdata: 32'hDEADBEEF, exp_hresp: RespError};
    tab[4] = '{write: 1'b0, addr: 32'h2014, wdata: 32'h0, htrans: TransNonseq,
               hburst: BurstSingle, aw: 1, dw: 0, rdata: 32'hCAFEF00D, resp: RespOkay,
               exp_lo: 3, exp_hrdata: 32'hCAFEF00D, exp_hresp: RespOkay};
    tab[5] = '{write: 1'b1, addr: 32'h200C, wdata: 32'h11223344, htrans: TransSeq,
               hburst: BurstIncr, aw: 0, dw: 2, rdata: 32'h0, resp: RespRetry,
               exp_lo: 5, exp_hrdata: 32'hCAFEF00D, exp_hresp: RespRetry};

    up_haddr = '0; up_htrans = TransIdle; up_hwrite = 1'b0; up_hsize = '0;
    up_hburst = '0; up_hprot = '0; up_hlock = 1'b0; up_hwdata = '0;
    dn_hrdata = '0; dn_hready = 1'b1; dn_hresp = RespOkay;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #1 reset_values("reset");
    #19 resetn = 1'b1;
    @(posedge hclk); #1;

    // Directed vectors
    for (int t = 0; t < 6; t++) begin
      run_xfer(tab[t], $sformatf("tab%0d", t));
    end
    idle_cycles(2, "tab end");
    mdl_rdata = tab[5].exp_hrdata;

    // INCR4 write burst at 0x3000, odd beats with an ADDR wait
    for (int b = 0; b < 4; b++) begin
      cur.write  = 1'b1;
      cur.addr   = 32'h3000 + 32'(4 * b);
      cur.wdata  = $urandom();
      cur.htrans = (b == 0) ? TransNonseq : TransSeq;
      cur.hburst = BurstIncr4;
      cur.aw     = b % 2;
      cur.dw     = 0;
      cur.rdata  = 32'h0;
      cur.resp   = RespOkay;
      run_xfer(model(cur), $sformatf("incr4 beat%0d", b));
    end
    idle_cycles(3, "incr4 end");

    // Randomized transfers against the model
    for (int n = 0; n < 40; n++) begin
      cur.write  = 1'($urandom_range(0, 1));
      cur.addr   = $urandom() & 32'hFFFF_FFFC;
      cur.wdata  = $urandom();
      cur.htrans = ($urandom_range(0, 1) == 1) ? TransSeq : TransNonseq;
      cur.hburst = 3'($urandom_range(0, 7));
      cur.aw     = int'($urandom_range(0, 2));
      cur.dw     = int'($urandom_range(0, 3));
      cur.rdata  = $urandom();
      cur.resp   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : RespOkay;
      run_xfer(model(cur), $sformatf("rnd%0d", n));
      gap = int'($urandom_range(0, 3));
      if (gap > 0) idle_cycles(gap, $sformatf("rnd%0d gap", n));
    end
    idle_cycles(2, "rnd end");

    // Reset during the DATA phase of a burst read with a downstream wait pending
    up_htrans = TransNonseq; up_haddr = 32'h4000; up_hwrite = 1'b0; up_hburst = BurstIncr4;
    dn_hready = 1'b1;
    @(negedge hclk);
    idle_check("rst pre");
    @(posedge hclk); #1;
    up_htrans = TransIdle;
    @(posedge hclk); #1;
    dn_hready = 1'b0;
    @(negedge hclk);
    chk("rst mid ready", 64'(o_hready[0]), 64'd0);
    chk("rst mid htrans dut1", 64'(o_htrans[1]), 64'(TransBusy));
    #1 resetn = 1'b0;
    #1 reset_values("async reset");
    @(posedge hclk); #1;
    dn_hready = 1'b1; dn_hresp = RespError; dn_hrdata = 32'hBAD0BAD0;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("post rst%0d ready dut%0d", i, k), 64'(o_hready[k]), 64'd1);
        chk($sformatf("post rst%0d hresp dut%0d", i, k), 64'(o_hresp[k]), 64'(RespOkay));
        chk($sformatf("post rst%0d hrdata dut%0d", i, k), 64'(o_hrdata[k]), 64'd0);
        chk($sformatf("post rst%0d htrans dut%0d", i, k), 64'(o_htrans[k]), 64'(TransIdle));
      end
      @(posedge hclk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
